// File: rtl/axis_header_scheduler.sv
// Round-robin header arbiter feeding an AXIS header inserter; one header per packet, registered outputs.
// Grant and valid_insert appear 1 cycle after a request; the header is held until ready_insert, then the next grant waits for the packet's last beat.
module axis_header_scheduler #(
    parameter int NUM_SRC      = 4,
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int SRC_ID_WD    = $clog2(NUM_SRC),
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic [NUM_SRC-1:0]              hdr_valid,
    input  logic [NUM_SRC*DATA_WD-1:0]      hdr_data,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0] hdr_keep,
    output logic [NUM_SRC-1:0]              hdr_ready,
    output logic                            valid_insert,
    output logic [DATA_WD-1:0]              data_insert,
    output logic [DATA_BYTE_WD-1:0]         keep_insert,
    output logic [BYTE_CNT_WD-1:0]          byte_insert_cnt,
    input  logic                            ready_insert,
    input  logic                            mon_valid,
    input  logic                            mon_ready,
    input  logic                            mon_last,
    output logic [SRC_ID_WD-1:0]            grant_id,
    output logic                            busy,
    output logic [15:0]                     pkt_cnt,
    output logic                            err_empty_hdr,
    output logic                            err_timeout
);

    localparam int TO_WD = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_WD-1:0] TO_MAX = TO_WD'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_PKT} state_t;

    state_t                  state;
    logic [SRC_ID_WD-1:0]    rr_ptr;
    logic [TO_WD-1:0]        to_cnt;

    logic                    win_found;
    logic [SRC_ID_WD-1:0]    win_id;
    logic [SRC_ID_WD-1:0]    scan_idx;
    logic [DATA_WD-1:0]      win_data;
    logic [DATA_BYTE_WD-1:0] win_keep;
    logic [BYTE_CNT_WD-1:0]  win_cnt;
    logic                    mon_beat;

    assign mon_beat = mon_valid && mon_ready;

    // Scan starts just after the last winner, wrapping, so every requester is served in turn.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            scan_idx = SRC_ID_WD'((int'(rr_ptr) + i) % NUM_SRC);
            if (!win_found && hdr_valid[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end
    end

    assign win_data = hdr_data[win_id*DATA_WD +: DATA_WD];
    assign win_keep = hdr_keep[win_id*DATA_BYTE_WD +: DATA_BYTE_WD];

    // Popcount wraps at BYTE_CNT_WD bits, so a full beat encodes as 0.
    always_comb begin
        win_cnt = '0;
        for (int b = 0; b < DATA_BYTE_WD; b++) begin
            win_cnt = win_cnt + BYTE_CNT_WD'(win_keep[b]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            rr_ptr          <= SRC_ID_WD'(NUM_SRC - 1);
            to_cnt          <= '0;
            hdr_ready       <= '0;
            valid_insert    <= 1'b0;
            data_insert     <= '0;
            keep_insert     <= '0;
            byte_insert_cnt <= '0;
            grant_id        <= '0;
            busy            <= 1'b0;
            pkt_cnt         <= '0;
            err_empty_hdr   <= 1'b0;
            err_timeout     <= 1'b0;
        end else begin
            hdr_ready     <= '0;
            err_empty_hdr <= 1'b0;
            err_timeout   <= 1'b0;
            case (state)
                IDLE: begin
                    // While an ack is visible the source has not yet dropped its request; skip that cycle.
                    if (en && win_found && (hdr_ready == '0)) begin
                        hdr_ready       <= NUM_SRC'(1) << win_id;
                        data_insert     <= win_data;
                        keep_insert     <= win_keep;
                        byte_insert_cnt <= win_cnt;
                        grant_id        <= win_id;
                        rr_ptr          <= win_id;
                        if (win_keep == '0) begin
                            err_empty_hdr <= 1'b1;
                        end else begin
                            valid_insert <= 1'b1;
                            busy         <= 1'b1;
                            state        <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (ready_insert) begin
                        valid_insert <= 1'b0;
                        to_cnt       <= '0;
                        state        <= WAIT_PKT;
                    end
                end
                WAIT_PKT: begin
                    if (mon_beat && mon_last) begin
                        pkt_cnt <= pkt_cnt + 16'd1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (mon_beat) begin
                        to_cnt <= '0;
                    end else if ((TIMEOUT_CYC != 0) && (to_cnt == TO_MAX)) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_WD'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_header_scheduler.sv
// Directed bench for axis_header_scheduler: table of single-packet vectors plus hand sequences for stalls, empty headers, timeout and reset.
module tb_axis_header_scheduler;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int BW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic [NS-1:0]   hdr_valid = '0;
    logic [NS*DW-1:0] hdr_data;
    logic [NS*BW-1:0] hdr_keep;
    logic [NS-1:0]   hdr_ready;
    logic            valid_insert;
    logic [DW-1:0]   data_insert;
    logic [BW-1:0]   keep_insert;
    logic [1:0]      byte_insert_cnt;
    logic            ready_insert = 1'b0;
    logic            mon_valid = 1'b0;
    logic            mon_ready = 1'b0;
    logic            mon_last = 1'b0;
    logic [1:0]      grant_id;
    logic            busy;
    logic [15:0]     pkt_cnt;
    logic            err_empty_hdr;
    logic            err_timeout;

    logic [DW-1:0]   src_data [NS];
    logic [BW-1:0]   src_keep [NS];

    int              n_pass = 0;
    int              n_total = 0;
    logic [15:0]     exp_pkt = '0;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] base;
        logic [3:0]  keep;
        logic [1:0]  gnt;
        logic [31:0] dat;
        logic [1:0]  cnt;
    } vec_t;

    vec_t vecs [9];

    axis_header_scheduler #(
        .NUM_SRC(NS), .DATA_WD(DW), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .hdr_valid(hdr_valid), .hdr_data(hdr_data), .hdr_keep(hdr_keep), .hdr_ready(hdr_ready),
        .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
        .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
        .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_last(mon_last),
        .grant_id(grant_id), .busy(busy), .pkt_cnt(pkt_cnt),
        .err_empty_hdr(err_empty_hdr), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always_comb begin
        hdr_data = '0;
        hdr_keep = '0;
        for (int k = 0; k < NS; k++) begin
            hdr_data[k*DW +: DW] = src_data[k];
            hdr_keep[k*BW +: BW] = src_keep[k];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic set_src(input logic [31:0] base, input logic [3:0] keep);
        for (int k = 0; k < NS; k++) begin
            src_data[k] = base ^ 32'(k);
            src_keep[k] = keep;
        end
    endtask

    // Raise req, wait (bounded) for the ack, then verify grant and presented header.
    task automatic grant_chk(input string nm, input logic [3:0] req, input logic [1:0] g,
                             input logic [31:0] d, input logic [3:0] kp, input logic [1:0] c);
        int lat;
        hdr_valid = req;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            tick;
            lat = i;
            if (hdr_ready != '0) break;
        end
        check({nm, "_lat"}, 64'(lat), 64'd1);
        check({nm, "_rdy"}, 64'(hdr_ready), 64'(4'b0001 << g));
        check({nm, "_gnt"}, 64'(grant_id), 64'(g));
        check({nm, "_vld"}, 64'(valid_insert), 64'd1);
        check({nm, "_dat"}, 64'(data_insert), 64'(d));
        check({nm, "_keep"}, 64'(keep_insert), 64'(kp));
        check({nm, "_cnt"}, 64'(byte_insert_cnt), 64'(c));
        check({nm, "_busy"}, 64'(busy), 64'd1);
    endtask

    task automatic handshake(input string nm);
        ready_insert = 1'b1;
        tick;
        ready_insert = 1'b0;
        check({nm, "_vld_drop"}, 64'(valid_insert), 64'd0);
        check({nm, "_rdy_pulse"}, 64'(hdr_ready), 64'd0);
    endtask

    task automatic finish_pkt(input string nm);
        mon_valid = 1'b1;
        mon_ready = 1'b1;
        mon_last  = 1'b0;
        tick;
        tick;
        check({nm, "_busy_mid"}, 64'(busy), 64'd1);
        mon_last  = 1'b1;
        hdr_valid = '0;
        tick;
        mon_valid = 1'b0;
        mon_ready = 1'b0;
        mon_last  = 1'b0;
        exp_pkt   = exp_pkt + 16'd1;
        check({nm, "_pkt"}, 64'(pkt_cnt), 64'(exp_pkt));
        check({nm, "_idle"}, 64'(busy), 64'd0);
        check({nm, "_dead"}, 64'(valid_insert), 64'd0);
    endtask

    initial begin
        logic seen;
        vecs[0] = '{4'b1111, 32'h5555_0000, 4'b1111, 2'd0, 32'h5555_0000, 2'd0};
        vecs[1] = '{4'b1111, 32'h5555_0000, 4'b1111, 2'd1, 32'h5555_0001, 2'd0};
        vecs[2] = '{4'b1111, 32'h5555_0000, 4'b1111, 2'd2, 32'h5555_0002, 2'd0};
        vecs[3] = '{4'b1111, 32'h5555_0000, 4'b1111, 2'd3, 32'h5555_0003, 2'd0};
        vecs[4] = '{4'b1111, 32'h5555_0000, 4'b1111, 2'd0, 32'h5555_0000, 2'd0};
        vecs[5] = '{4'b0001, 32'hAABB_CCDD, 4'b1111, 2'd0, 32'hAABB_CCDD, 2'd0};
        vecs[6] = '{4'b0001, 32'h0000_0011, 4'b0001, 2'd0, 32'h0000_0011, 2'd1};
        vecs[7] = '{4'b1000, 32'h1234_5678, 4'b0111, 2'd3, 32'h1234_567B, 2'd3};
        vecs[8] = '{4'b0010, 32'hCAFE_F00D, 4'b1010, 2'd1, 32'hCAFE_F00C, 2'd2};
        set_src(32'h0, 4'b0);

        tick;
        tick;
        check("rst_vld", 64'(valid_insert), 64'd0);
        check("rst_rdy", 64'(hdr_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_misc", 64'({data_insert, keep_insert, byte_insert_cnt, grant_id, pkt_cnt,
                               err_empty_hdr, err_timeout}), 64'd0);
        rst_n = 1'b1;
        en    = 1'b1;

        for (int v = 0; v < 9; v++) begin
            set_src(vecs[v].base, vecs[v].keep);
            grant_chk($sformatf("vec%0d", v), vecs[v].req, vecs[v].gnt, vecs[v].dat,
                      vecs[v].keep, vecs[v].cnt);
            handshake($sformatf("vec%0d", v));
            finish_pkt($sformatf("vec%0d", v));
        end

        // en low blocks arbitration but not a packet already in flight
        set_src(32'h0BAD_0000, 4'b1111);
        en = 1'b0;
        hdr_valid = 4'b0001;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (hdr_ready != '0 || busy) seen = 1'b1;
        end
        check("en_block", 64'(seen), 64'd0);
        en = 1'b1;
        grant_chk("en", 4'b0001, 2'd0, 32'h0BAD_0000, 4'b1111, 2'd0);
        en = 1'b0;
        handshake("en");
        finish_pkt("en");
        en = 1'b1;

        // ready_insert withheld for 5 cycles
        set_src(32'hDEAD_BEEF, 4'b1100);
        grant_chk("bp", 4'b0100, 2'd2, 32'hDEAD_BEED, 4'b1100, 2'd2);
        hdr_valid = '0;
        for (int i = 1; i <= 5; i++) begin
            tick;
            check($sformatf("bp_vld%0d", i), 64'(valid_insert), 64'd1);
            check($sformatf("bp_dat%0d", i), 64'(data_insert), 64'(32'hDEAD_BEED));
            check($sformatf("bp_keep%0d", i), 64'(keep_insert), 64'(4'b1100));
        end
        handshake("bp");
        finish_pkt("bp");

        // empty header from source 2
        set_src(32'h7777_0000, 4'b1111);
        src_keep[2] = 4'b0000;
        hdr_valid = 4'b0100;
        tick;
        check("empty_rdy", 64'(hdr_ready), 64'(4'b0100));
        check("empty_err", 64'(err_empty_hdr), 64'd1);
        check("empty_vld", 64'(valid_insert), 64'd0);
        check("empty_busy", 64'(busy), 64'd0);
        hdr_valid = 4'b1100;
        src_keep[2] = 4'b1111;
        tick;
        check("empty_err_pulse", 64'(err_empty_hdr), 64'd0);
        check("empty_gap_rdy", 64'(hdr_ready), 64'd0);
        check("empty_gap_vld", 64'(valid_insert), 64'd0);
        grant_chk("after_empty", 4'b1100, 2'd3, 32'h7777_0003, 4'b1111, 2'd0);
        hdr_valid = '0;
        handshake("after_empty");
        finish_pkt("after_empty");

        // idle timeout: no monitor beats after the handshake
        set_src(32'h0000_AAAA, 4'b1111);
        grant_chk("to", 4'b0001, 2'd0, 32'h0000_AAAA, 4'b1111, 2'd0);
        hdr_valid = '0;
        handshake("to");
        seen = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick;
            if (err_timeout || !busy) seen = 1'b1;
        end
        check("to_early", 64'(seen), 64'd0);
        tick;
        check("to_err", 64'(err_timeout), 64'd1);
        check("to_busy", 64'(busy), 64'd0);
        check("to_pkt", 64'(pkt_cnt), 64'(exp_pkt));
        tick;
        check("to_pulse", 64'(err_timeout), 64'd0);

        // last beat lands on the expiry cycle
        set_src(32'h0000_BBBB, 4'b0011);
        grant_chk("tol", 4'b0010, 2'd1, 32'h0000_BBBA, 4'b0011, 2'd2);
        hdr_valid = '0;
        handshake("tol");
        for (int i = 1; i <= 7; i++) tick;
        mon_valid = 1'b1;
        mon_ready = 1'b1;
        mon_last  = 1'b1;
        tick;
        mon_valid = 1'b0;
        mon_ready = 1'b0;
        mon_last  = 1'b0;
        exp_pkt = exp_pkt + 16'd1;
        check("tol_err", 64'(err_timeout), 64'd0);
        check("tol_busy", 64'(busy), 64'd0);
        check("tol_pkt", 64'(pkt_cnt), 64'(exp_pkt));

        // asynchronous reset while waiting for the packet
        set_src(32'h0000_CCCC, 4'b1111);
        grant_chk("pre_rst", 4'b0100, 2'd2, 32'h0000_CCCE, 4'b1111, 2'd0);
        hdr_valid = '0;
        handshake("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_outs", 64'({hdr_ready, valid_insert, data_insert, keep_insert, byte_insert_cnt,
                                grant_id, busy, pkt_cnt, err_empty_hdr, err_timeout}), 64'd0);
        exp_pkt = '0;
        tick;
        tick;
        rst_n = 1'b1;
        set_src(32'h0000_DDDD, 4'b1111);
        grant_chk("post_rst", 4'b0100, 2'd2, 32'h0000_DDDF, 4'b1111, 2'd0);
        hdr_valid = '0;
        handshake("post_rst");
        finish_pkt("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/axis_header_scheduler.md
Name: axis_header_scheduler

Overview:
- Controller for the AXI-Stream header-insert datapath.
- Arbitrates round-robin among NUM_SRC header requesters and presents exactly one header per packet on the inserter's header port (valid_insert/data_insert/keep_insert/byte_insert_cnt/ready_insert).
- Watches the inserter's output stream and blocks the next header until the current packet's last beat is taken.
- Optional idle timeout recovers from a stalled packet.

Parameters:
- NUM_SRC, 4, number of header requesters (2..8).
- DATA_WD, 32, header/data width in bits.
- DATA_BYTE_WD, DATA_WD/8, bytes per beat.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of byte_insert_cnt.
- SRC_ID_WD, $clog2(NUM_SRC), width of grant_id.
- TIMEOUT_CYC, 1024, idle cycles in WAIT_PKT before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  allow new arbitration
- hdr_valid  in  NUM_SRC  per-source header request
- hdr_data  in  NUM_SRC*DATA_WD  packed headers; source k at [k*DATA_WD +: DATA_WD]
- hdr_keep  in  NUM_SRC*DATA_BYTE_WD  packed keeps
- hdr_ready  out  NUM_SRC  one-hot accept pulse
- valid_insert  out  1  to inserter
- data_insert  out  DATA_WD  to inserter
- keep_insert  out  DATA_BYTE_WD  to inserter
- byte_insert_cnt  out  BYTE_CNT_WD  to inserter
- ready_insert  in  1  from inserter
- mon_valid  in  1  inserter valid_out
- mon_ready  in  1  inserter ready_out
- mon_last  in  1  inserter last_out
- grant_id  out  SRC_ID_WD  source owning the current packet
- busy  out  1  state != IDLE
- pkt_cnt  out  16  completed packets, wraps
- err_empty_hdr  out  1  1-cycle pulse
- err_timeout  out  1  1-cycle pulse

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, rr_ptr=NUM_SRC-1 so source 0 wins first. Reset mid-packet aborts immediately; the next header is issued only after a fresh request.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_PKT.
- IDLE, en=1 and any hdr_valid:
  - Winner = first set bit scanning from rr_ptr+1 with wrap.
  - hdr_ready[winner]=1 on the next cycle for exactly one cycle; header, keep, byte count and grant_id are latched the same cycle; rr_ptr=winner.
  - Next state ISSUE, so valid_insert rises 1 cycle after the request is seen.
  - Sources must hold hdr_valid and data until hdr_ready.
  - en=0 blocks arbitration only; an in-flight packet completes normally.
- Empty header (latched keep == 0): the source is still acked, but the block asserts err_empty_hdr, stays in IDLE, leaves valid_insert low and still advances rr_ptr.
- byte_insert_cnt = popcount(keep) truncated to BYTE_CNT_WD; a full beat (DATA_BYTE_WD=4) encodes as 0. keep is not checked for contiguity.
- ISSUE:
  - valid_insert=1; data_insert, keep_insert and byte_insert_cnt are held stable until valid_insert && ready_insert.
  - On that handshake: valid_insert=0 next cycle, state WAIT_PKT, timeout counter cleared.
- WAIT_PKT:
  - On mon_valid && mon_ready && mon_last: state IDLE, pkt_cnt+1.
  - IDLE may arbitrate the following cycle, giving 1 dead cycle minimum between a last beat and the next valid_insert.
  - Timeout counter: cleared on any mon_valid && mon_ready beat, otherwise +1.
  - When the counter reaches TIMEOUT_CYC-1 with no beat: err_timeout pulse, state IDLE, pkt_cnt unchanged.
  - A last beat in the same cycle as expiry counts as completion; no error.
- mon_* activity in IDLE or ISSUE is ignored.
- hdr_valid changes in ISSUE or WAIT_PKT are ignored; no preemption.

Test Plan:
- Single source, headers 0xAABBCCDD/keep 4'b1111 then 0x11/keep 4'b0001 -> hdr_ready[0] pulses; valid_insert 1 cycle later with byte_insert_cnt 0 then 1; second valid_insert only ≥1 cycle after the first mon_last handshake; pkt_cnt=2.
- hdr_valid=4'b1111 held for 4 packets -> grant_id sequence 0,1,2,3, then 0 again; each hdr_ready is one-hot and a single cycle.
- ready_insert held low 5 cycles in ISSUE -> valid_insert stays 1 and data_insert/keep_insert stay constant across all 6 cycles.
- Source 2 sends keep 4'b0000 -> hdr_ready[2] pulse, err_empty_hdr pulse, valid_insert never rises; next request goes to source 3 first.
- TIMEOUT_CYC=8, no mon beat after the insert handshake -> err_timeout pulses, busy falls, pkt_cnt unchanged; variant with a last beat on the expiry cycle -> no error, pkt_cnt+1.
- Assert rst_n mid WAIT_PKT -> all outputs 0 asynchronously; after release with hdr_valid=4'b0100, grant_id=2 and normal issue.
